pll_reset_ctrl: RTL and testbench

Reset sequencer and lock supervisor for the system PLL (50 MHz reference in; 48/48/12 MHz out). Runs on the PLL reference clock. Holds the PLL in reset for a minimum time, then waits for a filtered lock with a timeout and retries. Releases the system reset only after lock has been stable for a programmable window, and re-sequences on lock loss or on a soft reset request.

---
 rtl/pll_reset_ctrl.sv | 127 ++++++++++++
 tb/tb_pll_reset_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer and lock supervisor clocked by the PLL reference clock.
// Holds the PLL in reset, qualifies a synchronized lock, then releases the system reset.
module pll_reset_ctrl #(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 1024
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    input  logic       req_reset,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [3:0] fail_count,
    output logic [1:0] state
);

    localparam int MAX_AB     = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYCLES = (MAX_AB > LOCK_STABLE) ? MAX_AB : LOCK_STABLE;
    localparam int CW         = $clog2(MAX_CYCLES) + 1;

    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);

    typedef enum logic [1:0] {
        RESET_PLL = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_n;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_n;
    logic          locked_m;
    logic          locked_s;
    logic          fail_inc;

    // locked comes straight from the PLL analog block, so it is resynchronized first
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            locked_m <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            locked_m <= locked;
            locked_s <= locked_m;
        end
    end

    always_comb begin
        state_n  = state_r;
        cnt_n    = cnt_r + CW'(1);
        fail_inc = 1'b0;
        case (state_r)
            RESET_PLL: begin
                if (req_reset) begin
                    cnt_n = '0;
                end else if (cnt_r == RST_LAST) begin
                    state_n = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (!locked_s && cnt_r == TIMEOUT_LAST) begin
                    state_n  = RESET_PLL;
                    fail_inc = 1'b1;
                end else if (req_reset) begin
                    state_n = RESET_PLL;
                end else if (locked_s) begin
                    state_n = STABLE;
                end
            end
            STABLE: begin
                // a soft request wins over both the lock drop and the stable count
                if (req_reset) begin
                    state_n = RESET_PLL;
                end else if (!locked_s) begin
                    state_n = WAIT_LOCK;
                end else if (cnt_r == STABLE_LAST) begin
                    state_n = RUN;
                end
            end
            RUN: begin
                cnt_n = '0;
                if (!locked_s) begin
                    state_n  = RESET_PLL;
                    fail_inc = 1'b1;
                end else if (req_reset) begin
                    state_n = RESET_PLL;
                end
            end
            default: begin
                state_n = RESET_PLL;
                cnt_n   = '0;
            end
        endcase
        if (state_n != state_r) begin
            cnt_n = '0;
        end
    end

    // outputs are decoded from the next state so they change on the same edge as the state
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_r    <= RESET_PLL;
            cnt_r      <= '0;
            fail_count <= 4'd0;
            pll_rst    <= 1'b1;
            sys_rst    <= 1'b1;
            ready      <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            if (fail_inc && fail_count != 4'hF) begin
                fail_count <= fail_count + 4'd1;
            end
            pll_rst <= (state_n == RESET_PLL);
            sys_rst <= (state_n != RUN);
            ready   <= (state_n == RUN);
        end
    end

    assign state = state_r;

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Self-checking bench for pll_reset_ctrl: directed test-plan steps followed by
// randomized lock/soft-reset traffic, all compared against a behavioural model.
module tb_pll_reset_ctrl;

    localparam int RST_CYCLES   = 4;
    localparam int LOCK_TIMEOUT = 20;
    localparam int LOCK_STABLE  = 8;

    logic       refclk = 1'b0;
    logic       rst;
    logic       locked;
    logic       req_reset;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [3:0] fail_count;
    logic [1:0] state;

    int tests    = 0;
    int failures = 0;

    // model: phase 0 hold, 1 lock wait, 2 qualify, 3 run; held = edges spent in phase
    int   m_phase;
    int   m_held;
    int   m_fails;
    logic m_pipe0;
    logic m_pipe1;

    pll_reset_ctrl #(
        .RST_CYCLES  (RST_CYCLES),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .LOCK_STABLE (LOCK_STABLE)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .locked    (locked),
        .req_reset (req_reset),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .fail_count(fail_count),
        .state     (state)
    );

    always #5 refclk = ~refclk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic modelReset();
        m_phase = 0;
        m_held  = 0;
        m_fails = 0;
        m_pipe0 = 1'b0;
        m_pipe1 = 1'b0;
    endtask

    task automatic modelEnter(input int p);
        m_phase = p;
        m_held  = 0;
    endtask

    task automatic modelFail();
        if (m_fails < 15) m_fails = m_fails + 1;
    endtask

    // one rising edge of the reference clock as seen by the model
    task automatic modelEdge();
        logic seen;
        seen    = m_pipe1;
        m_pipe1 = m_pipe0;
        m_pipe0 = locked;
        case (m_phase)
            0: begin
                if (req_reset) m_held = 0;
                else if (m_held + 1 >= RST_CYCLES) modelEnter(1);
                else m_held = m_held + 1;
            end
            1: begin
                if (!seen && m_held + 1 >= LOCK_TIMEOUT) begin
                    modelFail();
                    modelEnter(0);
                end else if (req_reset) modelEnter(0);
                else if (seen) modelEnter(2);
                else m_held = m_held + 1;
            end
            2: begin
                if (req_reset) modelEnter(0);
                else if (!seen) modelEnter(1);
                else if (m_held + 1 >= LOCK_STABLE) modelEnter(3);
                else m_held = m_held + 1;
            end
            default: begin
                if (!seen) begin
                    modelFail();
                    modelEnter(0);
                end else if (req_reset) modelEnter(0);
            end
        endcase
    endtask

    task automatic checkOutput(input string tag);
        tests = tests + 5;
        assert (pll_rst === (m_phase == 0)) else begin
            failures++;
            $error("[TB] FAIL %s pll_rst observed=%b expected=%b", tag, pll_rst, (m_phase == 0));
        end
        assert (sys_rst === (m_phase != 3)) else begin
            failures++;
            $error("[TB] FAIL %s sys_rst observed=%b expected=%b", tag, sys_rst, (m_phase != 3));
        end
        assert (ready === (m_phase == 3)) else begin
            failures++;
            $error("[TB] FAIL %s ready observed=%b expected=%b", tag, ready, (m_phase == 3));
        end
        assert (fail_count === 4'(m_fails)) else begin
            failures++;
            $error("[TB] FAIL %s fail_count observed=%0d expected=%0d", tag, fail_count, m_fails);
        end
        assert (state === 2'(m_phase)) else begin
            failures++;
            $error("[TB] FAIL %s state observed=%0d expected=%0d", tag, state, m_phase);
        end
    endtask

    task automatic checkValue(input string tag, input int observed, input int expected);
        tests++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic lk, input logic rq);
        locked    = lk;
        req_reset = rq;
    endtask

    task automatic tick(input string tag);
        @(posedge refclk);
        modelEdge();
        #1;
        checkOutput(tag);
    endtask

    task automatic runWhilePll(input logic val, input string tag, output int n);
        n = 0;
        do begin
            tick(tag);
            n++;
        end while (pll_rst === val && n < 200);
    endtask

    task automatic runUntilReady(input string tag, output int n);
        n = 0;
        do begin
            tick(tag);
            n++;
        end while (ready !== 1'b1 && n < 200);
    endtask

    task automatic runUntilState(input logic [1:0] s, input string tag, output int n);
        n = 0;
        do begin
            tick(tag);
            n++;
        end while (state !== s && n < 200);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        modelReset();
        @(posedge refclk);
        #1;
        checkOutput("por");
        @(posedge refclk);
        #1;
        checkOutput("por_hold");
        rst = 1'b0;

        // power-up lock
        runWhilePll(1'b1, "pwr_hold", n);
        checkValue("pwr_pll_high", n, RST_CYCLES);
        for (int i = 0; i < 3; i++) tick("pwr_wait");
        applyStimulus(1'b1, 1'b0);
        runUntilReady("pwr_lock", n);
        checkValue("pwr_lock_to_ready", n, 2 + 1 + LOCK_STABLE);
        checkValue("pwr_fail", fail_count, 0);
        checkValue("pwr_state", state, 3);

        // soft reset in RUN, then a second pulse while holding the PLL
        applyStimulus(1'b1, 1'b1);
        tick("soft_req");
        applyStimulus(1'b1, 1'b0);
        checkValue("soft_pll_rst", pll_rst, 1);
        checkValue("soft_sys_rst", sys_rst, 1);
        checkValue("soft_fail", fail_count, 0);
        tick("soft_hold");
        tick("soft_hold");
        applyStimulus(1'b1, 1'b1);
        tick("soft_req2");
        applyStimulus(1'b1, 1'b0);
        runWhilePll(1'b1, "soft_hold2", n);
        checkValue("soft_extend", n, RST_CYCLES);
        runUntilReady("soft_relock", n);
        checkValue("soft_relock_state", state, 3);

        // lock loss in RUN
        applyStimulus(1'b0, 1'b0);
        tick("loss_sync");
        tick("loss_sync");
        checkValue("loss_ready_held", ready, 1);
        tick("loss_act");
        checkValue("loss_ready", ready, 0);
        checkValue("loss_sys_rst", sys_rst, 1);
        checkValue("loss_pll_rst", pll_rst, 1);
        checkValue("loss_fail", fail_count, 1);
        runWhilePll(1'b1, "loss_hold", n);
        checkValue("loss_pll_high", n, RST_CYCLES);
        for (int i = 0; i < 3; i++) tick("loss_wait");
        applyStimulus(1'b1, 1'b0);

        // lock glitch while qualifying
        runUntilState(2'd2, "glitch_enter", n);
        checkValue("glitch_reach_stable", state, 2);
        for (int i = 0; i < 5; i++) tick("glitch_stable");
        applyStimulus(1'b0, 1'b0);
        tick("glitch_low");
        tick("glitch_low");
        applyStimulus(1'b1, 1'b0);
        tick("glitch_back");
        checkValue("glitch_state", state, 1);
        checkValue("glitch_fail", fail_count, 1);
        runUntilReady("glitch_relock", n);
        checkValue("glitch_lock_to_ready", n + 1, 2 + 1 + LOCK_STABLE);

        // timeout retries with lock held low, fail count saturates
        @(posedge refclk);
        #3;
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0);
        modelReset();
        #1;
        checkOutput("to_reset");
        @(posedge refclk);
        #1;
        rst = 1'b0;
        for (int a = 1; a <= 16; a++) begin
            runWhilePll(1'b1, "to_high", n);
            checkValue("to_pll_high", n, RST_CYCLES);
            runWhilePll(1'b0, "to_low", n);
            checkValue("to_pll_low", n, LOCK_TIMEOUT);
            checkValue("to_fail", fail_count, (a > 15) ? 15 : a);
        end

        // async reset while qualifying
        applyStimulus(1'b1, 1'b0);
        runUntilState(2'd2, "ar_enter", n);
        checkValue("ar_reach_stable", state, 2);
        tick("ar_stable");
        tick("ar_stable");
        #2;
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("ar_async");
        @(posedge refclk);
        #1;
        checkOutput("ar_hold");
        rst = 1'b0;
        runWhilePll(1'b1, "ar_seq", n);
        checkValue("ar_pll_high", n, RST_CYCLES);
        runUntilReady("ar_relock", n);
        checkValue("ar_relock_edges", n, 1 + LOCK_STABLE);

        // randomized lock drops and soft reset requests
        for (int i = 0; i < 2500; i++) begin
            logic lk;
            lk = locked;
            if ($urandom_range(0, 39) == 0) lk = ~lk;
            applyStimulus(lk, ($urandom_range(0, 79) == 0));
            tick("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
